// File: rtl/debug_pkg.sv
// Shared debug-unit package: TX FSM state encoding and the UART framing constants
// used by both the debug word transmitter and the program-loading receiver.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } txState_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 5208;  // 100 MHz / 19200 baud
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-cycle tick every CLKS_PER_BIT cycles. The clear input
// restarts the period so the first bit after a request is a full bit long.
module uart_baud_tick
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (clear)        cnt <= '0;
        else if (cnt == LAST)  cnt <= '0;
        else                   cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/debug_word_tx.sv
// Sends 32-bit debug words to the host as WORD_BYTES UART frames, MSB byte first,
// LSB bit first. Define DEBUG_TX_PARITY_EN for 8E1 frames; default is 8N1.
module debug_word_tx
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        out_ready,
    output logic        out_busy,
    output logic        out_done,
    output logic        TX
);

    localparam int                BYTE_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    txState_t          state,    stateNxt;
    logic [31:0]       shiftReg, shiftNxt;
    logic [BYTE_W-1:0] byteCnt,  byteNxt;
    logic [2:0]        bitIdx,   bitNxt;
    logic              txNxt;
    logic              accept;
    logic              baudTick;

    // DONE behaves as IDLE so a queued word follows the last stop bit directly.
    assign out_ready = (state == IDLE) || (state == DONE);
    assign out_busy  = !out_ready;
    assign out_done  = (state == DONE);
    assign accept    = in_valid && out_ready;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baudGen (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (baudTick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            byteCnt  <= '0;
            bitIdx   <= '0;
            TX       <= STOP_BIT;
        end else begin
            state    <= stateNxt;
            shiftReg <= shiftNxt;
            byteCnt  <= byteNxt;
            bitIdx   <= bitNxt;
            TX       <= txNxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        stateNxt = state;
        shiftNxt = shiftReg;
        byteNxt  = byteCnt;
        bitNxt   = bitIdx;
        txNxt    = TX;
        case (state)
            IDLE, DONE: begin
                stateNxt = IDLE;
                txNxt    = STOP_BIT;
                if (accept) begin
                    stateNxt = START;
                    shiftNxt = in_word;
                    byteNxt  = '0;
                    bitNxt   = '0;
                    txNxt    = START_BIT;
                end
            end
            START: if (baudTick) begin
                stateNxt = DATA;
                txNxt    = shiftReg[24];
            end
            DATA: if (baudTick) begin
                // Rotating the current byte brings it back intact after eight bits.
                shiftNxt[31:24] = {shiftReg[24], shiftReg[31:25]};
                if (bitIdx == LAST_BIT) begin
                    bitNxt = '0;
`ifdef DEBUG_TX_PARITY_EN
                    stateNxt = PARITY;
                    txNxt    = ^shiftReg[31:24];
`else
                    stateNxt = STOP;
                    txNxt    = STOP_BIT;
`endif
                end else begin
                    bitNxt = bitIdx + 3'd1;
                    txNxt  = shiftReg[25];
                end
            end
`ifdef DEBUG_TX_PARITY_EN
            PARITY: if (baudTick) begin
                stateNxt = STOP;
                txNxt    = STOP_BIT;
            end
`endif
            STOP: if (baudTick) begin
                if (byteCnt == LAST_BYTE) begin
                    stateNxt = DONE;
                    byteNxt  = '0;
                end else begin
                    stateNxt = START;
                    byteNxt  = byteCnt + BYTE_W'(1);
                    shiftNxt = shiftReg << 8;
                    txNxt    = START_BIT;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule
